i2c_req_arbiter: RTL

Shares the single I2C byte engine behind the axi_iic block between NREQ hardware requesters, such as the sensor poller, the LED/GPO configurator and the software bridge. It grants requesters round-robin and expands each granted register-access request into the byte-engine command sequence. It also collects the engine responses, detects NACK and timeout, and returns the result to the owning requester.

---
 rtl/i2c_req_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C byte engine between NREQ requesters.
// Expands each granted register access into START/WRITE/READ_NACK/STOP commands.
module i2c_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic                axi_aclk,
    input  logic                axi_areset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_reg,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     done_valid,
    output logic [7:0]          done_rdata,
    output logic                done_nack,
    output logic                done_timeout,
    output logic                busy,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [2:0]          cmd_op,
    output logic [7:0]          cmd_wdata,
    input  logic                resp_valid,
    input  logic                resp_nack,
    input  logic [7:0]          resp_rdata
);
    // state | meaning
    // IDLE  | no owner; grant the next pending requester round-robin
    // ISSUE | present the command for the current step until the engine takes it
    // WAIT  | wait for the engine response, with timeout
    // DONE  | done pulse to the owner is visible; release the engine
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ_NACK = 3'd2;
    localparam logic [2:0] OP_STOP      = 3'd3;

    state_t          state_q;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   owner_q;
    logic            rw_q;
    logic [6:0]      addr_q;
    logic [7:0]      reg_q;
    logic [7:0]      wdata_q;
    logic [2:0]      step_q;
    logic            nack_q;
    logic [7:0]      rdata_q;
    logic [TW-1:0]   tcnt_q;

    logic [6:0] addr_a  [NREQ];
    logic [7:0] reg_a   [NREQ];
    logic [7:0] wdata_a [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[7*g +: 7];
        assign reg_a[g]   = req_reg[8*g +: 8];
        assign wdata_a[g] = req_wdata[8*g +: 8];
    end

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   cand;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_q;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Write: START, W{a,0}, W reg, W data, STOP.
    // Read:  START, W{a,0}, W reg, START, W{a,1}, READ_NACK, STOP.
    function automatic logic [10:0] step_cmd(input logic rw, input logic [2:0] step,
                                             input logic [6:0] a, input logic [7:0] r,
                                             input logic [7:0] w);
        case (step)
            3'd0:    step_cmd = {OP_START, 8'h00};
            3'd1:    step_cmd = {OP_WRITE, a, 1'b0};
            3'd2:    step_cmd = {OP_WRITE, r};
            3'd3:    step_cmd = rw ? {OP_START, 8'h00} : {OP_WRITE, w};
            3'd4:    step_cmd = rw ? {OP_WRITE, a, 1'b1} : {OP_STOP, 8'h00};
            3'd5:    step_cmd = {OP_READ_NACK, 8'h00};
            default: step_cmd = {OP_STOP, 8'h00};
        endcase
    endfunction

    logic [2:0] stop_step;
    logic       write_nacked;
    assign stop_step    = rw_q ? 3'd6 : 3'd4;
    assign write_nacked = (cmd_op == OP_WRITE) && resp_nack;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q      <= S_IDLE;
            last_q       <= IW'(NREQ - 1);
            owner_q      <= '0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            step_q       <= '0;
            nack_q       <= 1'b0;
            rdata_q      <= '0;
            tcnt_q       <= '0;
            req_ready    <= '0;
            done_valid   <= '0;
            done_rdata   <= '0;
            done_nack    <= 1'b0;
            done_timeout <= 1'b0;
            busy         <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_op       <= '0;
            cmd_wdata    <= '0;
        end else begin
            req_ready  <= '0;
            done_valid <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (gnt_found) begin
                        req_ready <= NREQ'(1) << gnt_idx;
                        owner_q   <= gnt_idx;
                        last_q    <= gnt_idx;
                        rw_q      <= req_rw[gnt_idx];
                        addr_q    <= addr_a[gnt_idx];
                        reg_q     <= reg_a[gnt_idx];
                        wdata_q   <= wdata_a[gnt_idx];
                        step_q    <= '0;
                        nack_q    <= 1'b0;
                        rdata_q   <= '0;
                        busy      <= 1'b1;
                        state_q   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!cmd_valid) begin
                        cmd_valid            <= 1'b1;
                        {cmd_op, cmd_wdata}  <= step_cmd(rw_q, step_q, addr_q, reg_q, wdata_q);
                    end else if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        tcnt_q    <= '0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        if (cmd_op == OP_READ_NACK)
                            rdata_q <= resp_rdata;
                        if (step_q == stop_step) begin
                            done_valid   <= NREQ'(1) << owner_q;
                            done_rdata   <= rdata_q;
                            done_nack    <= nack_q;
                            done_timeout <= 1'b0;
                            state_q      <= S_DONE;
                        end else begin
                            // a NACKed byte skips straight to STOP
                            step_q  <= write_nacked ? stop_step : step_q + 3'd1;
                            nack_q  <= nack_q | write_nacked;
                            state_q <= S_ISSUE;
                        end
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        done_valid   <= NREQ'(1) << owner_q;
                        done_rdata   <= rdata_q;
                        done_nack    <= nack_q;
                        done_timeout <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
